// File: rtl/alu_shift_pkg.sv
// Shared types and constants for the sequential ALU shift path.
package alu_shift_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;

    // Stage amounts, largest first; stage k handles rem bit (SHW-1-k).
    localparam int unsigned SH_16 = 16;
    localparam int unsigned SH_8  = 8;
    localparam int unsigned SH_4  = 4;
    localparam int unsigned SH_2  = 2;
    localparam int unsigned SH_1  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/left_shift_stage.sv
// One step of the sequential left shifter: applies the largest pending
// power-of-two shift and clears its bit from the remaining amount.
module left_shift_stage
    import alu_shift_pkg::*;
#(
    parameter int unsigned W  = WIDTH,
    parameter int unsigned SW = SHW
) (
    input  logic [W-1:0]  data_i,
    input  logic [SW-1:0] rem_i,
    output logic [W-1:0]  data_o,
    output logic [SW-1:0] rem_o
);

    always_comb begin
        data_o = data_i;
        rem_o  = rem_i;
        if (rem_i[4]) begin
            data_o   = data_i << SH_16;
            rem_o[4] = 1'b0;
        end else if (rem_i[3]) begin
            data_o   = data_i << SH_8;
            rem_o[3] = 1'b0;
        end else if (rem_i[2]) begin
            data_o   = data_i << SH_4;
            rem_o[2] = 1'b0;
        end else if (rem_i[1]) begin
            data_o   = data_i << SH_2;
            rem_o[1] = 1'b0;
        end else if (rem_i[0]) begin
            data_o   = data_i << SH_1;
            rem_o[0] = 1'b0;
        end
    end

endmodule

// File: rtl/seq_left_shifter.sv
// Multi-cycle logical left shifter: one power-of-two stage per cycle,
// done pulse on completion, result held until the next accepted start.
module seq_left_shifter
    import alu_shift_pkg::*;
#(
    parameter int unsigned WIDTH = alu_shift_pkg::WIDTH,
    parameter int unsigned SHW   = alu_shift_pkg::SHW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0] stage_data;
    logic [SHW-1:0]   stage_rem;
    logic             accept;

    left_shift_stage #(
        .W  (WIDTH),
        .SW (SHW)
    ) u_stage (
        .data_i (data_q),
        .rem_i  (rem_q),
        .data_o (stage_data),
        .rem_o  (stage_rem)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    data_d  = A;
                    rem_d   = shamt;
                    state_d = (shamt != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d  = stage_data;
                rem_d   = stage_rem;
                state_d = (stage_rem == '0) ? ST_DONE : ST_SHIFT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        result = data_q;
        busy   = (state_q == ST_SHIFT);
        done   = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_seq_left_shifter.sv
// Directed self-checking bench for seq_left_shifter; inputs driven and
// outputs sampled on the falling clock edge.
module tb_seq_left_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int busy_cycles;

    seq_left_shifter #(
        .WIDTH (32),
        .SHW   (5)
    ) dut (
        .clock  (clk),
        .reset  (rst),
        .start  (start),
        .A      (a),
        .shamt  (shamt),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [31:0] res_exp,
                                input logic busy_exp, input logic done_exp);
        check({tag, ".result"}, result, res_exp);
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, busy_exp});
        check({tag, ".done"}, {31'd0, done}, {31'd0, done_exp});
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        shamt = '0;
        repeat (2) @(negedge clk);
        check_status("reset", 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_status("idle", 32'h0, 1'b0, 1'b0);

        // Reset during the second SHIFT cycle of a 31-bit shift
        start = 1'b1; a = 32'h0000_00FF; shamt = 5'd31;
        @(negedge clk);
        start = 1'b0;
        check_status("rstmid.s1", 32'h0000_00FF, 1'b1, 1'b0);
        @(negedge clk);
        check_status("rstmid.s2", 32'h00FF_0000, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check_status("rstmid.async", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; a = 32'h0000_0001; shamt = 5'd2;
        @(negedge clk);
        start = 1'b0;
        check_status("after_rst.s1", 32'h0000_0001, 1'b1, 1'b0);
        @(negedge clk);
        check_status("after_rst.done", 32'h0000_0004, 1'b0, 1'b1);
        @(negedge clk);

        // Single bit: shamt=4, done two cycles after the start edge
        start = 1'b1; a = 32'h0000_0001; shamt = 5'd4;
        @(negedge clk);
        start = 1'b0;
        check_status("single.s1", 32'h0000_0001, 1'b1, 1'b0);
        @(negedge clk);
        check_status("single.done", 32'h0000_0010, 1'b0, 1'b1);
        @(negedge clk);
        check_status("single.hold", 32'h0000_0010, 1'b0, 1'b0);

        // Full amount: five SHIFT cycles
        start = 1'b1; a = 32'hFFFF_FFFF; shamt = 5'd31;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 12 && busy; i++) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("full.busy_cycles", busy_cycles, 32'd5);
        check_status("full.done", 32'h8000_0000, 1'b0, 1'b1);
        @(negedge clk);
        check_status("full.idle", 32'h8000_0000, 1'b0, 1'b0);

        // Zero shift: straight to DONE, busy never seen
        start = 1'b1; a = 32'hDEAD_BEEF; shamt = 5'd0;
        @(negedge clk);
        start = 1'b0;
        check_status("zero.done", 32'hDEAD_BEEF, 1'b0, 1'b1);
        @(negedge clk);
        check_status("zero.idle", 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Start while busy is ignored
        start = 1'b1; a = 32'h0000_0003; shamt = 5'd5;
        @(negedge clk);
        check_status("ign.s1", 32'h0000_0003, 1'b1, 1'b0);
        a = 32'h1234_5678; shamt = 5'd1;
        @(negedge clk);
        start = 1'b0;
        check_status("ign.s2", 32'h0000_0030, 1'b1, 1'b0);
        @(negedge clk);
        check_status("ign.done", 32'h0000_0060, 1'b0, 1'b1);
        @(negedge clk);
        check_status("ign.idle", 32'h0000_0060, 1'b0, 1'b0);
        @(negedge clk);
        check_status("ign.idle2", 32'h0000_0060, 1'b0, 1'b0);

        // Back-to-back: new start accepted in the DONE cycle
        start = 1'b1; a = 32'h8000_0001; shamt = 5'd1;
        @(negedge clk);
        start = 1'b0;
        check_status("b2b.s1", 32'h8000_0001, 1'b1, 1'b0);
        @(negedge clk);
        check_status("b2b.done1", 32'h0000_0002, 1'b0, 1'b1);
        start = 1'b1; a = 32'h0000_000F; shamt = 5'd8;
        @(negedge clk);
        start = 1'b0;
        check_status("b2b.s2", 32'h0000_000F, 1'b1, 1'b0);
        @(negedge clk);
        check_status("b2b.done2", 32'h0000_0F00, 1'b0, 1'b1);
        @(negedge clk);
        check_status("b2b.idle", 32'h0000_0F00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_left_shifter.md
Name: seq_left_shifter

Overview:
- Multi-cycle logical left shifter for the ALU shift path; it is the left-direction counterpart of the fixed right-shift stages.
- Takes a 32-bit operand and a 5-bit shift amount on a start pulse.
- Each cycle it applies one power-of-two shift (16/8/4/2/1), always the largest still pending, and fills vacated low bits with zero.
- Signals completion with a one-cycle done pulse and holds the result until the next start.

Parameters:
- WIDTH, 32, operand/result width; must equal 2^SHW
- SHW, 5, shift-amount width

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request pulse; sampled only when state is IDLE or DONE
- A  input  WIDTH  operand, captured on an accepted start
- shamt  input  SHW  shift amount 0..31, captured on an accepted start
- result  output  WIDTH  shifted value; valid from the done cycle until the next accepted start
- busy  output  1  high while state is SHIFT
- done  output  1  one-cycle pulse when result becomes valid

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; internal data register=0; remaining-amount register=0.
  - result=0, busy=0, done=0.
  - Any operation in flight is discarded.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- Accept: start=1 at a rising edge while state is IDLE or DONE.
  - data<=A; rem<=shamt.
  - Next state is SHIFT if shamt!=0, else DONE.
- start while state=SHIFT is ignored. It is not queued and has no effect on the operation in progress.
- SHIFT, at each edge:
  - Let b be the highest set bit of rem.
  - data<=data<<(2^b), zero fill, truncated to WIDTH.
  - Clear bit b of rem.
  - If the cleared rem==0, next state is DONE; else stay in SHIFT.
- DONE:
  - done=1 for exactly this cycle.
  - Next state is IDLE, unless start=1, which is accepted as a new operation (back-to-back operation allowed).
- Latency: with start accepted at edge E0, done is high in the cycle following edge E0+popcount(shamt).
  - shamt=0 gives done one cycle after the accept.
  - shamt=31 gives 5 SHIFT cycles (maximum).
- result: continuously driven from the data register.
  - Meaningful in the DONE cycle and afterwards in IDLE.
  - Changes on an accepted start (to A, as an intermediate value) and during SHIFT.
  - Consumers must sample on done.
- busy=1 iff state==SHIFT; done=1 iff state==DONE.
- Arithmetic: pure logical shift. Bits shifted out past bit WIDTH-1 are lost. The sign is not preserved.
- Illegal state encoding: recover to IDLE on the next edge.

Decomposition:
- Shared package (alu_shift_pkg):
  - State type and encodings for IDLE/SHIFT/DONE.
  - WIDTH/SHW constants.
  - The stage-amount constants 16, 8, 4, 2, 1.
- One combinational sub-module, left_shift_stage:
  - Inputs: data and rem. Outputs: the shifted data and the next rem.
  - Implemented as a priority select over the five fixed left-shift wirings.
- The FSM and registers stay in seq_left_shifter.

Test Plan:
- Reset mid-op: start A=0x0000_00FF, shamt=31; assert reset during the 2nd SHIFT cycle -> result=0, busy=0, done=0 immediately. The next start behaves normally.
- Single bit: A=0x0000_0001, shamt=4 -> one SHIFT cycle; done pulse; result=0x0000_0010. Total latency 2 cycles from the start edge.
- Full amount: A=0xFFFF_FFFF, shamt=31 -> busy for 5 cycles, then done; result=0x8000_0000.
- Zero shift: A=0xDEAD_BEEF, shamt=0 -> done one cycle after the accept; result=0xDEAD_BEEF; busy never asserted.
- Ignored start: A=0x0000_0003, shamt=5; pulse start with A=0x1234_5678, shamt=1 while busy -> result=0x0000_0060. Exactly one done pulse.
- Back-to-back: start A=0x8000_0001, shamt=1; assert start with A=0x0000_000F, shamt=8 in the DONE cycle -> first result=0x0000_0002, then the second done gives 0x0000_0F00. No idle cycle between the two operations.
